// File: rtl/alu_pkg.sv
// Shared types for the ALU and its requester arbiter: opcode enum,
// arbiter FSM states and the datapath width.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU: alu_op, in_a, in_b -> result, zero.
// Opcodes outside alu_op_t give result 0 (zero = 1).
module alu
    import alu_pkg::*;
(
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_AND: result = in_a & in_b;
            ALU_OR:  result = in_a | in_b;
            ALU_ADD: result = in_a + in_b;
            ALU_SUB: result = in_a - in_b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: one-hot grant of the first set bit
// of req, searching from index ptr upward and wrapping. Ports: req, ptr, grant.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters: round-robin grant, one op in
// flight, FSM IDLE -> EXEC -> RESP. Ports: clk, rst_n (async, active-low),
// req_valid/req_ready/req_op/req_a/req_b, rsp_valid/rsp_ready/rsp_result/
// rsp_zero, busy, and grant_cnt (only when ALU_ARB_STATS_EN is defined).
module alu_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int STAT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0][3:0]  req_op,
    input  logic [NUM_REQ-1:0][31:0] req_a,
    input  logic [NUM_REQ-1:0][31:0] req_b,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [31:0]              rsp_result,
    output logic                     rsp_zero,
`ifdef ALU_ARB_STATS_EN
    output logic [NUM_REQ-1:0][STAT_WIDTH-1:0] grant_cnt,
`endif
    output logic                     busy
);

    import alu_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || STAT_WIDTH < 1) begin : g_bad_param
        $error("alu_arbiter: NUM_REQ must be 2..8, STAT_WIDTH >= 1");
    end

    arb_state_t state_q;
    arb_state_t state_d;

    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   owner_q;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   rr_next;
    logic [NUM_REQ-1:0] grant;
    logic               accept;
    logic               owner_taken;

    logic [3:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    alu u_alu (
        .alu_op (op_q),
        .in_a   (a_q),
        .in_b   (b_q),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // rst_n gating keeps req_ready low while reset is held,
    // even if requesters keep req_valid asserted.
    assign req_ready = (rst_n && state_q == IDLE) ? grant : '0;
    assign accept    = |req_ready;
    assign busy      = (state_q != IDLE);

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = (state_q == RESP) && (owner_q == PTR_W'(i));
        end
    end

    assign owner_taken = rsp_ready[owner_q];

    assign rr_next = (owner_q == PTR_W'(NUM_REQ - 1)) ?
                     '0 : owner_q + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (owner_taken) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= req_op[grant_idx];
                a_q     <= req_a[grant_idx];
                b_q     <= req_b[grant_idx];
                owner_q <= grant_idx;
            end
            if (state_q == EXEC) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
            end
            // Pointer moves past the owner only once its result is taken.
            if (state_q == RESP && owner_taken) begin
                rr_ptr_q <= rr_next;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && req_valid[i] && grant_cnt[i] != '1) begin
                    grant_cnt[i] <= grant_cnt[i] + STAT_WIDTH'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed cases plus random traffic
// checked against an arbitration/ALU reference model.
module tb_alu_arbiter;

    localparam int N  = 2;
    localparam int SW = 16;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_RESP = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0]         req_ready;
    logic [N-1:0][3:0]    req_op = '0;
    logic [N-1:0][31:0]   req_a = '0;
    logic [N-1:0][31:0]   req_b = '0;
    logic [N-1:0]         rsp_valid;
    logic [N-1:0]         rsp_ready = '0;
    logic [31:0]          rsp_result;
    logic                 rsp_zero;
    logic                 busy;
`ifdef ALU_ARB_STATS_EN
    logic [N-1:0][SW-1:0] grant_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int          owner;
        logic [31:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   glog[$];
    int   hs_count[N];
    int   gcnt[N];
    int   m_state = M_IDLE;
    int   m_rr = 0;
    int   m_owner = 0;
    int   m_due = 0;

    alu_arbiter #(
        .NUM_REQ    (N),
        .STAT_WIDTH (SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
`ifdef ALU_ARB_STATS_EN
        .grant_cnt  (grant_cnt),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int pick(logic [N-1:0] v, int rr);
        for (int k = 0; k < N; k++) begin
            if (v[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    // Reference model: one op at a time, round-robin from the last
    // served requester, result two cycles after the grant is seen.
    always @(negedge clk or negedge rst_n) begin
        int p;
        logic [N-1:0] exp_rdy;
        if (!rst_n) begin
            exp_q.delete();
            m_state = M_IDLE;
            m_rr = 0;
            for (int i = 0; i < N; i++) gcnt[i] = 0;
        end else begin
            if (m_state == M_WAIT && cyc >= m_due) m_state = M_RESP;
            if (m_state == M_IDLE) begin
                p = pick(req_valid, m_rr);
                exp_rdy = '0;
                if (p >= 0) exp_rdy[p] = 1'b1;
                chk("req_ready", req_ready, exp_rdy);
                chk("idle_busy_rsp", {busy, rsp_valid}, '0);
                if (p >= 0) begin
                    exp_q.push_back('{p, ref_alu(req_op[p], req_a[p], req_b[p])});
                    hs_count[p]++;
                    gcnt[p]++;
                    glog.push_back(p);
                    m_owner = p;
                    m_due = cyc + 2;
                    m_state = M_WAIT;
                end
            end else if (m_state == M_WAIT) begin
                chk("exec_outs", {busy, rsp_valid, req_ready}, {1'b1, {2*N{1'b0}}});
            end else begin
                exp_rdy = '0;
                exp_rdy[m_owner] = 1'b1;
                chk("rsp_valid", rsp_valid, exp_rdy);
                chk("resp_busy_rdy", {busy, req_ready}, {1'b1, {N{1'b0}}});
                if (exp_q.size() > 0) begin
                    chk("rsp_result", rsp_result, exp_q[0].res);
                    chk("rsp_zero", rsp_zero, exp_q[0].res == 32'h0);
                end
                if (rsp_ready[m_owner]) begin
                    if (exp_q.size() > 0) exp_q.delete(0);
                    m_rr = (m_owner + 1) % N;
                    m_state = M_IDLE;
                end
            end
        end
    end

    task automatic set_req(int i, logic [3:0] op, logic [31:0] a, logic [31:0] b);
        req_op[i] = op;
        req_a[i] = a;
        req_b[i] = b;
        req_valid[i] = 1'b1;
    endtask

    task automatic rand_req(int i);
        logic [3:0] op;
        logic [31:0] a;
        logic [31:0] b;
        case ($urandom_range(7, 0))
            0: op = 4'b0000;
            1, 7: op = 4'b0001;
            2, 3: op = 4'b0010;
            4, 5: op = 4'b0110;
            default: op = 4'($urandom());
        endcase
        a = ($urandom_range(3, 0) == 0) ? 32'h0 : $urandom();
        b = ($urandom_range(3, 0) == 0) ? 32'hffffffff : $urandom();
        set_req(i, op, a, b);
    endtask

    task automatic wait_hs(int i, int s);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (hs_count[i] == s && k < 60);
        #1;
        chk("hs_seen", hs_count[i] != s, 1);
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(int i, logic [31:0] res, logic z);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (rsp_valid[i]) break;
        end
        chk("dir_rsp_valid", rsp_valid[i], 1);
        chk("dir_result", rsp_result, res);
        chk("dir_zero", rsp_zero, z);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain", k < 200, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random(int n);
        int seen[N];
        for (int i = 0; i < N; i++) seen[i] = hs_count[i];
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i]) begin
                    if (hs_count[i] != seen[i]) begin
                        seen[i] = hs_count[i];
                        if ($urandom_range(1, 0) == 1) rand_req(i);
                        else req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(2, 0) == 0) begin
                    rand_req(i);
                end
                rsp_ready[i] = ($urandom_range(3, 0) != 0);
            end
        end
        req_valid = '0;
        rsp_ready = '1;
    endtask

    initial begin
        int s0;
        int s1;
        int base;
        int seen[N];

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {req_ready, rsp_valid, busy, rsp_zero}, '0);
        chk("rst_result", rsp_result, 32'h0);
`ifdef ALU_ARB_STATS_EN
        chk("rst_cnt", grant_cnt, '0);
`endif
        @(posedge clk);
        #3 rst_n = 1'b1;

        // contention straight after reset: req0 wins, then req1
        rsp_ready = '1;
        @(posedge clk);
        #1;
        set_req(0, 4'b0000, 32'hffffffff, 32'h00ff00ff);
        set_req(1, 4'b0110, 32'd5, 32'd6);
        s0 = hs_count[0];
        s1 = hs_count[1];
        wait_hs(0, s0);
        wait_rsp(0, 32'h00ff00ff, 1'b0);
        wait_hs(1, s1);
        wait_rsp(1, 32'hffffffff, 1'b0);
        drain();

        // fairness: both held valid for six grants
        base = glog.size();
        for (int i = 0; i < N; i++) seen[i] = hs_count[i];
        set_req(0, 4'b0010, $urandom(), $urandom());
        set_req(1, 4'b0010, $urandom(), $urandom());
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (glog.size() - base >= 6) break;
            for (int i = 0; i < N; i++) begin
                if (hs_count[i] != seen[i]) begin
                    seen[i] = hs_count[i];
                    set_req(i, 4'b0010, $urandom(), $urandom());
                end
            end
        end
        req_valid = '0;
        chk("fair_count", glog.size() - base >= 6, 1);
        for (int k = 0; k < 6; k++) begin
            if (base + k < glog.size()) chk("fair_order", glog[base + k], k % 2);
        end
        drain();

        // single ADD, then idle on the next cycle
        set_req(0, 4'b0010, 32'd5, 32'd6);
        s0 = hs_count[0];
        wait_hs(0, s0);
        wait_rsp(0, 32'd11, 1'b0);
        @(posedge clk);
        #1;
        chk("t1_busy", busy, 1'b0);
        drain();

        // backpressure on req1 while req0 waits
        rsp_ready = 2'b01;
        set_req(1, 4'b0110, 32'h80000000, 32'h1);
        s1 = hs_count[1];
        wait_hs(1, s1);
        set_req(0, 4'b0010, 32'd1, 32'd2);
        s0 = hs_count[0];
        wait_rsp(1, 32'h7fffffff, 1'b0);
        repeat (10) begin
            @(negedge clk);
            chk("bp_hold", {rsp_valid, rsp_result, req_ready}, {2'b10, 32'h7fffffff, 2'b00});
        end
        @(posedge clk);
        #1 rsp_ready = '1;
        wait_hs(0, s0);
        wait_rsp(0, 32'd3, 1'b0);
        drain();

        // zero result and undefined opcode
        set_req(0, 4'b0001, 32'h0, 32'h0);
        s0 = hs_count[0];
        wait_hs(0, s0);
        wait_rsp(0, 32'h0, 1'b1);
        set_req(1, 4'b1110, 32'd5, 32'h2222);
        s1 = hs_count[1];
        wait_hs(1, s1);
        wait_rsp(1, 32'h0, 1'b1);
        drain();

        drive_random(2000);
        drain();
`ifdef ALU_ARB_STATS_EN
        chk("cnt0_model", grant_cnt[0], gcnt[0]);
        chk("cnt1_model", grant_cnt[1], gcnt[1]);
`endif

        // reset while the op is executing
        set_req(1, 4'b0010, 32'd7, 32'd8);
        s1 = hs_count[1];
        wait_hs(1, s1);
        chk("pre_rst_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {req_ready, rsp_valid, busy, rsp_zero}, '0);
        chk("mid_rst_result", rsp_result, 32'h0);
`ifdef ALU_ARB_STATS_EN
        chk("mid_rst_cnt", grant_cnt, '0);
`endif
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("no_rsp_after_rst", {rsp_valid, busy}, '0);
        for (int k = 0; k < 3; k++) begin
            set_req(1, 4'b0010, 32'd3, 32'(k));
            s1 = hs_count[1];
            wait_hs(1, s1);
            wait_rsp(1, 32'(3 + k), 1'b0);
            drain();
        end
`ifdef ALU_ARB_STATS_EN
        chk("cnt1_after3", grant_cnt[1], 3);
        chk("cnt0_after3", grant_cnt[0], 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
